// File: rtl/excp_pkg.sv
// Shared definitions for the MEM/WB exception controller: exception codes,
// CP0 register addresses, exception-flag bit positions and FSM states.
package excp_pkg;

  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_ADES = 5'h0b;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;
  localparam logic [4:0] EXC_ERET = 5'h0e;
  localparam logic [4:0] EXC_ADEL = 5'h0f;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EBASE  = 5'd15;

  localparam int unsigned FLG_SYSCALL = 0;
  localparam int unsigned FLG_RI      = 1;
  localparam int unsigned FLG_TRAP    = 2;
  localparam int unsigned FLG_OV      = 3;
  localparam int unsigned FLG_ERET    = 4;
  localparam int unsigned FLG_ADEL    = 5;
  localparam int unsigned FLG_ADES    = 6;
  localparam int unsigned FLG_W       = 7;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  // Handler address: EBase page (low 12 bits dropped) plus vector offset.
  function automatic logic [31:0] vec_addr(input logic [31:0] ebase,
                                           input logic [31:0] offset);
    return {ebase[31:12], 12'h000} + offset;
  endfunction

endpackage

// File: rtl/excp_ctrl_prio_enc.sv
// Combinational priority encoder selecting the exception code to take from
// the instruction's exception flags and the interrupt-pending condition.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic [FLG_W-1:0] flags,
  input  logic             int_pending,
  output logic [4:0]       code,
  output logic             taken
);

  always_comb begin
    code  = '0;
    taken = 1'b1;
    if (int_pending)              code = EXC_INT;
    else if (flags[FLG_ADEL])     code = EXC_ADEL;
    else if (flags[FLG_RI])       code = EXC_RI;
    else if (flags[FLG_OV])       code = EXC_OV;
    else if (flags[FLG_TRAP])     code = EXC_TR;
    else if (flags[FLG_SYSCALL])  code = EXC_SYS;
    else if (flags[FLG_ADES])     code = EXC_ADES;
    else if (flags[FLG_ERET])     code = EXC_ERET;
    else                          taken = 1'b0;
  end

endmodule

// File: rtl/excp_ctrl.sv
// MEM/WB exception controller: forwards in-flight mtc0 writes, picks the
// exception to take, reports it to CP0 and flushes/redirects the pipeline.
// Optional statistics outputs are enabled with `define EXCP_STATS_EN.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter logic [31:0] VEC_OFFSET   = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic [31:0]      pc_i,
  input  logic             in_delay_slot_i,
  input  logic [FLG_W-1:0] excp_flags_i,
  input  logic [31:0]      bad_addr_i,
  input  logic [31:0]      status_i,
  input  logic [31:0]      cause_i,
  input  logic [31:0]      epc_i,
  input  logic [31:0]      ebase_i,
  input  logic             wb_cp0_we_i,
  input  logic [4:0]       wb_cp0_waddr_i,
  input  logic [31:0]      wb_cp0_data_i,
  output logic [31:0]      excepttype_o,
  output logic [31:0]      current_inst_addr_o,
  output logic             is_in_delay_slot_o,
  output logic [31:0]      bad_address_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
`ifdef EXCP_STATS_EN
  output logic [31:0]      excp_count_o,
  output logic [4:0]       last_code_o,
`endif
  output logic             busy_o
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  flush_cnt;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_pending;
  logic [4:0]  enc_code;
  logic        enc_taken;
  logic        take;
  logic [31:0] target_pc;
  logic [31:0] new_pc_q;

  // Effective CP0 view including an mtc0 that is retiring this cycle.
  always_comb begin
    status_eff = status_i;
    cause_eff  = cause_i;
    epc_eff    = epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_STATUS: status_eff = wb_cp0_data_i;
        CP0_CAUSE: begin
          cause_eff[9:8]   = wb_cp0_data_i[9:8];
          cause_eff[23:22] = wb_cp0_data_i[23:22];
        end
        CP0_EPC:   epc_eff = wb_cp0_data_i;
        default:   ;
      endcase
    end
  end

  assign int_pending = status_eff[0] & ~status_eff[1]
                     & (|(cause_eff[15:8] & status_eff[15:8]));

  excp_prio_enc u_prio_enc (
    .flags       (excp_flags_i),
    .int_pending (int_pending),
    .code        (enc_code),
    .taken       (enc_taken)
  );

  assign take      = (state == IDLE) & valid_i & ~stall_i & enc_taken;
  assign target_pc = (enc_code == EXC_ERET) ? epc_eff : vec_addr(ebase_i, VEC_OFFSET);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; the flush counter alone decides when FLUSH ends.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    flush_o  = 1'b0;
    busy_o   = 1'b0;
    new_pc_o = '0;
    if (state == FLUSH) begin
      flush_o  = 1'b1;
      busy_o   = 1'b1;
      new_pc_o = new_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
      new_pc_q  <= '0;
    end else if (take) begin
      flush_cnt <= FLUSH_LAST;
      new_pc_q  <= target_pc;
    end else if (state == FLUSH && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

  // CP0 report: a one-cycle pulse per taken exception, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delay_slot_o  <= 1'b0;
      bad_address_o       <= '0;
    end else if (take) begin
      excepttype_o        <= {27'd0, enc_code};
      current_inst_addr_o <= pc_i;
      is_in_delay_slot_o  <= in_delay_slot_i;
      bad_address_o       <= bad_addr_i;
    end else begin
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      is_in_delay_slot_o  <= 1'b0;
      bad_address_o       <= '0;
    end
  end

`ifdef EXCP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_count_o <= '0;
      last_code_o  <= '0;
    end else if (take) begin
      last_code_o <= enc_code;
      if (enc_code != EXC_ERET && excp_count_o != '1)
        excp_count_o <= excp_count_o + 32'd1;
    end
  end
`endif

endmodule
